mem_access_stage: RTL and testbench

//  MEM pipeline stage downstream of EX. Takes the EX ALU result (address) and forwarded rs2 (store data).

---
 rtl/mem_access_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-memory handshake, store lane alignment, load extension
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output logic [31:0] mem_forward,
    output logic [31:0] mem_load_data,
    output logic        mem_misaligned,
    output logic        mem_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        legal, aligned, req, access, timeout_hit;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, ext_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
        case (funct3[1:0])
            2'b01:   aligned = ~alu_result[0];
            2'b10:   aligned = (alu_result[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        req         = mem_valid & (mem_read | mem_write);
        access      = req & legal & aligned;
        timeout_hit = (TIMEOUT_LIMIT != 32'd0) && (cnt_q + 32'd1 == TIMEOUT_LIMIT);

        case (funct3[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << alu_result[1:0];
                lane_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << alu_result[1:0];
                lane_wdata = {2{store_data[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = store_data;
            end
        endcase
        if (!mem_write) begin
            lane_be = 4'b0000;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        f3_d           = f3_q;
        rd_d           = rd_q;
        wr_d           = wr_q;
        buf_d          = buf_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        mem_stall      = 1'b0;
        mem_misaligned = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    mem_stall = 1'b1;
                    addr_d    = alu_result;
                    wdata_d   = lane_wdata;
                    be_d      = lane_be;
                    f3_d      = funct3;
                    // a simultaneous read+write is handled as a store
                    rd_d      = mem_read & ~mem_write;
                    wr_d      = mem_write;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    state_d   = S_WAIT;
                end else begin
                    mem_misaligned = req;
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q + 32'd1;
                if (dmem_resp) begin
                    buf_d   = dmem_rdata;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    buf_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld_byte = buf_q[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? buf_q[31:16] : buf_q[15:0];
        case (f3_q[1:0])
            2'b00:   ext_data = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
            2'b01:   ext_data = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
            default: ext_data = buf_q;
        endcase

        dmem_read        = (state_q == S_WAIT) & rd_q;
        dmem_write       = (state_q == S_WAIT) & wr_q;
        dmem_address     = {addr_q[31:2], 2'b00};
        dmem_wdata       = wdata_q;
        dmem_byte_enable = be_q;
        mem_err          = (state_q == S_DONE) & err_q;
        mem_load_data    = ((state_q == S_DONE) && rd_q) ? ext_data : 32'd0;
        case (state_q)
            S_DONE:  mem_forward = rd_q ? ext_data : addr_q;
            S_WAIT:  mem_forward = addr_q;
            default: mem_forward = alu_result;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - transaction-level model bench for mem_access_stage
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_stall;
    logic [31:0] mem_forward, mem_load_data;
    logic        mem_misaligned, mem_err;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .alu_result(alu_result), .store_data(store_data),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_stall(mem_stall), .mem_forward(mem_forward),
        .mem_load_data(mem_load_data), .mem_misaligned(mem_misaligned),
        .mem_err(mem_err)
    );

    typedef struct packed {
        logic rd, wr, stall, mis, err, c_lane, c_wd, c_fwd, c_ld;
        logic [31:0] addr, wdata, fwd, ld;
        logic [3:0]  be;
    } exp_t;

    typedef struct {
        int          stalls;
        logic [31:0] ld, wa, wd;
        logic [3:0]  wb;
        logic        err;
    } res_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t e;
    logic chk_en = 1'b0;
    res_t r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] d);
        logic [31:0] s;
        s = d >> (int'(o) * 8);
        case (f3)
            3'b000:  return 32'($signed(s[7:0]));
            3'b100:  return {24'd0, s[7:0]};
            3'b001:  return 32'($signed(s[15:0]));
            3'b101:  return {16'd0, s[15:0]};
            default: return d;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dmem_read", 32'(dmem_read), 32'(e.rd));
            chk("dmem_write", 32'(dmem_write), 32'(e.wr));
            chk("mem_stall", 32'(mem_stall), 32'(e.stall));
            chk("mem_misaligned", 32'(mem_misaligned), 32'(e.mis));
            chk("mem_err", 32'(mem_err), 32'(e.err));
            if (e.c_lane) begin
                chk("dmem_address", dmem_address, e.addr);
                chk("dmem_byte_enable", 32'(dmem_byte_enable), 32'(e.be));
            end
            if (e.c_wd) chk("dmem_wdata", dmem_wdata, e.wdata);
            if (e.c_fwd) chk("mem_forward", mem_forward, e.fwd);
            if (e.c_ld) chk("mem_load_data", mem_load_data, e.ld);
        end
    end

    task automatic op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd, input int nw,
                      input logic [31:0] rdat, output res_t res);
        int          sz, nwc;
        logic        legal, acc, st, tmo;
        logic [3:0]  mask;
        logic [31:0] wd;
        res_t        rr;
        rr.stalls = 0; rr.ld = '0; rr.wa = '0; rr.wd = '0; rr.wb = '0; rr.err = 1'b0;
        sz    = 1 << f3[1:0];
        legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        acc   = v && (rd || wr) && legal && ((int'(a[1:0]) % sz) == 0);
        st    = wr;
        mask  = st ? (4'((1 << sz) - 1) << a[1:0]) : 4'd0;
        if (sz == 1)      wd = {24'd0, sd[7:0]} * 32'h01010101;
        else if (sz == 2) wd = {16'd0, sd[15:0]} * 32'h00010001;
        else              wd = sd;

        @(posedge clk); #1;
        mem_valid = v; mem_read = rd; mem_write = wr; funct3 = f3;
        alu_result = a; store_data = sd; dmem_resp = 1'b0;
        e = '0;
        e.stall = acc; e.mis = v && (rd || wr) && !acc;
        e.c_fwd = 1'b1; e.fwd = a; e.c_ld = e.mis;
        chk_en = 1'b1;
        @(negedge clk);
        rr.stalls += int'(mem_stall);
        if (acc) begin
            tmo = (nw == 0) || (nw > TO);
            nwc = tmo ? TO : nw;
            for (int k = 1; k <= nwc; k++) begin
                @(posedge clk); #1;
                dmem_resp  = !tmo && (k == nwc);
                dmem_rdata = dmem_resp ? rdat : $urandom;
                e = '0;
                e.rd = !st; e.wr = st; e.stall = 1'b1;
                e.c_lane = 1'b1; e.addr = {a[31:2], 2'b00}; e.be = mask;
                e.c_wd = st; e.wdata = wd;
                @(negedge clk);
                rr.stalls += int'(mem_stall);
                if (k == 1) begin
                    rr.wa = dmem_address; rr.wd = dmem_wdata; rr.wb = dmem_byte_enable;
                end
            end
            // DONE cycle: present a misaligned load that must not re-trigger
            @(posedge clk); #1;
            dmem_resp = 1'b0; dmem_rdata = $urandom;
            mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
            alu_result = a | 32'd1; store_data = $urandom;
            e = '0;
            e.err = tmo;
            e.c_ld = !st; e.ld = tmo ? 32'd0 : m_ext(f3, a[1:0], rdat);
            e.c_fwd = 1'b1; e.fwd = st ? a : e.ld;
            @(negedge clk);
            rr.ld = mem_load_data; rr.err = mem_err;
        end
        res = rr;
    endtask

    task automatic chk_reset_outputs(input string tag, input logic [31:0] alu);
        chk({tag, "_dmem_read"}, 32'(dmem_read), 32'd0);
        chk({tag, "_dmem_write"}, 32'(dmem_write), 32'd0);
        chk({tag, "_dmem_address"}, dmem_address, 32'd0);
        chk({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
        chk({tag, "_dmem_byte_enable"}, 32'(dmem_byte_enable), 32'd0);
        chk({tag, "_mem_stall"}, 32'(mem_stall), 32'd0);
        chk({tag, "_mem_load_data"}, mem_load_data, 32'd0);
        chk({tag, "_mem_misaligned"}, 32'(mem_misaligned), 32'd0);
        chk({tag, "_mem_err"}, 32'(mem_err), 32'd0);
        chk({tag, "_mem_forward"}, mem_forward, alu);
    endtask

    initial begin
        rst = 1'b0;
        mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        alu_result = 32'h0000_0055; store_data = '0; dmem_rdata = '0; dmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset", 32'h0000_0055);
        rst = 1'b1;

        // 1: LW with response in the third WAIT cycle
        op(1, 1, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, r);
        chk("t1_stall_cycles", 32'(r.stalls), 32'd4);
        chk("t1_address", r.wa, 32'h100);
        chk("t1_load_data", r.ld, 32'hDEADBEEF);

        // 2: byte/half loads with sign and zero extension
        op(1, 1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80123456, r);
        chk("t2_lb", r.ld, 32'hFFFFFF80);
        chk("t2_latency_stalls", 32'(r.stalls), 32'd2);
        op(1, 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80123456, r);
        chk("t2_lbu", r.ld, 32'h00000080);
        op(1, 1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h80123456, r);
        chk("t2_lh", r.ld, 32'hFFFF8012);
        op(1, 1, 0, 3'b101, 32'h100, 32'h0, 1, 32'h80123456, r);
        chk("t2_lhu_low", r.ld, 32'h00003456);

        // 3: stores
        op(1, 0, 1, 3'b000, 32'h201, 32'h000000AB, 2, 32'h0, r);
        chk("t3_sb_address", r.wa, 32'h200);
        chk("t3_sb_mask", 32'(r.wb), 32'b0010);
        chk("t3_sb_wdata", r.wd, 32'hABABABAB);
        op(1, 0, 1, 3'b001, 32'h202, 32'h1234CAFE, 1, 32'h0, r);
        chk("t3_sh_mask", 32'(r.wb), 32'b1100);
        chk("t3_sh_wdata", r.wd, 32'hCAFECAFE);
        op(1, 1, 1, 3'b010, 32'h2F4, 32'h01020304, 2, 32'hFFFFFFFF, r);
        chk("t3_rdwr_as_sw_mask", 32'(r.wb), 32'b1111);

        // 4: misaligned / illegal / non-memory
        op(1, 1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0, r);
        chk("t4_misaligned_no_stall", 32'(r.stalls), 32'd0);
        op(1, 1, 0, 3'b101, 32'h101, 32'h0, 1, 32'h0, r);
        op(1, 0, 1, 3'b011, 32'h100, 32'h0, 1, 32'h0, r);
        op(1, 1, 0, 3'b110, 32'h100, 32'h0, 1, 32'h0, r);
        op(1, 0, 0, 3'b010, 32'h12345678, 32'h0, 1, 32'h0, r);
        op(0, 1, 0, 3'b011, 32'h87654321, 32'h0, 1, 32'h0, r);

        // a response pulse while IDLE is ignored
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        alu_result = 32'hA5A5_0000; dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111;
        e = '0; e.c_fwd = 1'b1; e.fwd = 32'hA5A5_0000;
        @(negedge clk);
        op(1, 1, 0, 3'b010, 32'h180, 32'h0, 1, 32'h2222_3333, r);
        chk("stray_resp_ignored", r.ld, 32'h2222_3333);

        // 5: timeout, and a response on the last allowed WAIT cycle
        op(1, 1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h0, r);
        chk("t5_timeout_stalls", 32'(r.stalls), 32'd5);
        chk("t5_timeout_err", 32'(r.err), 32'd1);
        chk("t5_timeout_load", r.ld, 32'd0);
        op(1, 1, 0, 3'b010, 32'h304, 32'h0, TO, 32'h0BAD_F00D, r);
        chk("t5_boundary_err", 32'(r.err), 32'd0);
        chk("t5_boundary_load", r.ld, 32'h0BAD_F00D);

        // 6: asynchronous reset in the middle of WAIT
        @(posedge clk); #1;
        chk_en = 1'b0;
        mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h400; dmem_resp = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("t6_read_before_reset", 32'(dmem_read), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_read_async_drop", 32'(dmem_read), 32'd0);
        mem_valid = 1'b0; mem_read = 1'b0; alu_result = 32'h0000_0077;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t6_after_reset", 32'h0000_0077);
        op(1, 1, 0, 3'b000, 32'h401, 32'h0, 1, 32'h0000_7F00, r);
        chk("t6_recover_lb", r.ld, 32'h0000007F);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
